bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly downstream of the 4x4 BCD-digit multiplier. It takes the multiplier's 8-bit binary product and returns packed BCD digits for the display/decoder stage.
- Converts one operand per request over WIDTH clock cycles, with a start/busy/done handshake.
- Holds the last result stable until the next conversion completes.

---
 rtl/bin2bcd_seq.sv | 140 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand per WIDTH cycles.
// Result and handshake outputs are registered; bcd only changes on the completion edge.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3    // must satisfy 10**DIGITS > 2**WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]    count_r, count_s;
    logic [WIDTH-1:0] operand_r, operand_s;
    logic [BW-1:0]    scratch_r, scratch_s;
    logic [BW-1:0]    bcd_r, bcd_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [BW-1:0]    adjusted_s;
    logic [BW-1:0]    shift_scratch_s;
    logic [WIDTH-1:0] shift_operand_s;
    logic             last_step_s;

    // Add 3 to every digit >= 5 so that the following shift carries correctly into the next digit.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    assign adjusted_s      = add3_digits(scratch_r);
    assign shift_scratch_s = {adjusted_s[BW-2:0], operand_r[WIDTH-1]};
    assign shift_operand_s = {operand_r[WIDTH-2:0], 1'b0};
    assign last_step_s     = (count_r == CW'(1));

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            count_r   <= '0;
            operand_r <= '0;
            scratch_r <= '0;
            bcd_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            operand_r <= operand_s;
            scratch_r <= scratch_s;
            bcd_r     <= bcd_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Next-state logic: start is only honoured from IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_step_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        count_s   = count_r;
        operand_s = operand_r;
        scratch_s = scratch_r;
        bcd_s     = bcd_r;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    operand_s = bin;
                    scratch_s = '0;
                    count_s   = CW'(WIDTH);
                    busy_s    = 1'b1;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            SHIFT: begin
                operand_s = shift_operand_s;
                scratch_s = shift_scratch_s;
                count_s   = count_r - CW'(1);
                if (last_step_s) begin
                    bcd_s  = shift_scratch_s;
                    done_s = 1'b1;
                    busy_s = 1'b0;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=3).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;

    int checks;
    int failures;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one start request for exactly one edge, then scramble bin.
    task automatic do_start(input logic [WIDTH-1:0] v);
        start = 1'b1;
        bin   = v;
        tick();
        start = 1'b0;
        bin   = WIDTH'($urandom);
    endtask

    // Count edges until done is seen (bounded); n = -1 on timeout. Also counts busy-low cycles seen before done.
    task automatic wait_done(output int n, output int busy_low);
        n = -1;
        busy_low = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
            if (!busy) busy_low++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bin = '0;
        #3;
        checks++;
        if ({busy, done, bcd} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b bcd=%h, want 0 0 000", busy, done, bcd);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, bcd} !== 14'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b bcd=%h, want 0 0 000", busy, done, bcd);
        end
    endtask

    task automatic test_zero();
        int n, bl;
        do_start(8'd0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_busy_rise: got %b want 1", busy);
        end
        wait_done(n, bl);
        checks++;
        if (n !== 8 || bl !== 0) begin
            failures++;
            $display("FAIL zero_latency: got %0d edges busy_low=%0d, want 8 edges busy_low=0", n, bl);
        end
        checks++;
        if (bcd !== 12'h000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_result: got bcd=%h busy=%b, want 000 0", bcd, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_pulse: got done=%b after one cycle, want 0", done);
        end
    endtask

    task automatic test_81();
        int n, bl;
        do_start(8'd81);
        wait_done(n, bl);
        checks++;
        if (n !== 8 || bcd !== 12'h081 || busy !== 1'b0) begin
            failures++;
            $display("FAIL conv_81: got edges=%0d bcd=%h busy=%b, want 8 081 0", n, bcd, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || bcd !== 12'h081) begin
            failures++;
            $display("FAIL hold_81: got done=%b bcd=%h, want 0 081", done, bcd);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0]    vals [3];
        logic [4*DIGITS-1:0] exp  [3];
        int n, bl;
        vals = '{8'd255, 8'd99, 8'd10};
        exp  = '{12'h255, 12'h099, 12'h010};
        do_start(vals[0]);
        wait_done(n, bl);
        checks++;
        if (n !== 8 || bcd !== exp[0]) begin
            failures++;
            $display("FAIL b2b_0: got edges=%0d bcd=%h, want 8 %h", n, bcd, exp[0]);
        end
        for (int k = 1; k < 3; k++) begin
            // start issued in the done cycle: next done follows 9 edges after the previous one
            do_start(vals[k]);
            checks++;
            if (busy !== 1'b1 || bcd !== exp[k-1]) begin
                failures++;
                $display("FAIL b2b_accept_%0d: got busy=%b bcd=%h, want 1 %h", k, busy, bcd, exp[k-1]);
            end
            wait_done(n, bl);
            checks++;
            if (n !== 8 || bcd !== exp[k]) begin
                failures++;
                $display("FAIL b2b_%0d: got edges=%0d bcd=%h, want 8 %h", k, n, bcd, exp[k]);
            end
        end
    endtask

    task automatic test_start_held();
        int n, bl;
        start = 1'b1;
        bin   = 8'd45;
        tick();
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            bin = bin + 8'd1;
            tick();
            if (done) begin
                n = i;
                break;
            end
            if (bcd !== 12'h010) begin
                n = -2;
            end
        end
        checks++;
        if (n !== 8 || bcd !== 12'h045) begin
            failures++;
            $display("FAIL held_first: got edges=%0d bcd=%h, want 8 045", n, bcd);
        end
        // bin is now 53 and start still high: accepted at this edge
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || bcd !== 12'h045) begin
            failures++;
            $display("FAIL held_hold: got busy=%b bcd=%h, want 1 045", busy, bcd);
        end
        wait_done(n, bl);
        checks++;
        if (n !== 8 || bcd !== 12'h053) begin
            failures++;
            $display("FAIL held_second: got edges=%0d bcd=%h, want 8 053", n, bcd);
        end
    endtask

    task automatic test_reset_mid();
        int n, bl, spurious;
        do_start(8'd81);
        wait_done(n, bl);
        checks++;
        if (bcd !== 12'h081) begin
            failures++;
            $display("FAIL mid_pre: got bcd=%h want 081", bcd);
        end
        do_start(8'd63);
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bcd} !== 14'd0) begin
            failures++;
            $display("FAIL mid_reset_async: got busy=%b done=%b bcd=%h, want 0 0 000", busy, done, bcd);
        end
        tick();
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) spurious++;
        end
        checks++;
        if (spurious !== 0 || bcd !== 12'h000) begin
            failures++;
            $display("FAIL mid_no_done: got %0d active cycles bcd=%h, want 0 000", spurious, bcd);
        end
        do_start(8'd63);
        wait_done(n, bl);
        checks++;
        if (n !== 8 || bcd !== 12'h063) begin
            failures++;
            $display("FAIL mid_restart: got edges=%0d bcd=%h, want 8 063", n, bcd);
        end
    endtask

    task automatic test_sweep();
        int n, bl;
        logic [4*DIGITS-1:0] exp;
        int bad_digit;
        for (int v = 0; v < 256; v++) begin
            do_start(WIDTH'(v));
            wait_done(n, bl);
            exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            bad_digit = 0;
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd[4*d +: 4] > 4'd9) bad_digit = 1;
            end
            checks++;
            if (n !== 8 || bcd !== exp || bad_digit !== 0) begin
                failures++;
                $display("FAIL sweep_%0d: got edges=%0d bcd=%h, want 8 %h", v, n, bcd, exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero();
        test_81();
        test_back_to_back();
        test_start_held();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
